serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake, then drives a single one-bit full-adder cell over WIDTH clock cycles, LSB first, with a registered carry between bits. Result and carry-out are presented on an output valid/ready handshake. This trades latency for area wherever a full ripple adder is not justified: one adder cell, shift registers and a small FSM.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, sampled on input handshake.
- b  input  WIDTH  operand B, sampled on input handshake.
- cin  input  1  carry-in, sampled on input handshake.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, low WIDTH bits.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

## Operation
- FSM states: IDLE, RUN, HOLD; encoding 2 bits.
- IDLE: in_ready=1. On in_valid&in_ready: a_sr<=a, b_sr<=b, carry<=cin, bit_cnt<=0, go RUN.
- RUN: one bit per cycle. s_bit = a_sr[0]^b_sr[0]^carry; c_bit = majority(a_sr[0],b_sr[0],carry). carry<=c_bit; a_sr, b_sr shift right; s_bit shifts into sum_sr MSB; bit_cnt++.
- When bit_cnt==WIDTH-1 in RUN: final bit processed, cout<=c_bit, go HOLD.
- HOLD: out_valid=1; sum, cout stable. On out_ready: go IDLE. out_valid drops the next cycle.
- in_ready is 0 in RUN and HOLD; in_valid there is ignored and operands are not sampled.
- No bypass: after the output handshake, at least one IDLE cycle precedes the next acceptance.
- bit_cnt width: $clog2(WIDTH). It never wraps because the FSM exits RUN at WIDTH-1.
- The result is modulo 2^WIDTH. cout carries the extra bit. No saturation.
- Reset at any time (including mid-RUN or in HOLD): state IDLE; sum, cout, ovf, out_valid, busy = 0; in_ready = 1 after reset deasserts. The partial operation is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
- Acceptance at edge E0. busy is high for cycles E0+1..E0+WIDTH. out_valid rises after edge E0+WIDTH.
- Latency is WIDTH cycles from acceptance to out_valid.
- Minimum initiation interval is WIDTH+2 cycles when out_ready is held high.
- All outputs are registered. There is no combinational path from in_valid/out_ready to any output.
- out_valid stays high and sum/cout are held indefinitely under backpressure.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - Adds the ovf port.
  - During the final RUN cycle, ovf <= carry-into-MSB ^ c_bit (two's-complement overflow).
  - ovf is valid with out_valid and follows the same reset and hold rules.
- SERIAL_ADD_OVF_EN undefined:
  - No ovf port and no overflow logic.
  - All other behaviour is identical.

## Structure
- Shared include/package serial_add_pkg:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2.
  - Default width constant SA_WIDTH_DEF=8.
- One natural sub-module, fa_cell: combinational one-bit full adder (inputs x,y,z; outputs s,c), instantiated once.
- The FSM, counter and shift registers live in serial_add_ctrl.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, cin=0 -> out_valid exactly 8 cycles after acceptance; sum=8'h10, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. With the macro: a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1; a=8'hFF, b=8'h01 -> ovf=0.
- a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0. a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Backpressure: out_ready low for 5 cycles after out_valid -> sum/cout stable, in_ready=0, and a second in_valid is not accepted. Release -> out_valid drops next cycle, in_ready=1.
- Assert rst after 3 RUN cycles -> immediately out_valid=0, busy=0, sum=0. Next op a=8'h55, b=8'hAA -> sum=8'hFF, cout=0.
- Back-to-back with out_ready=1 and in_valid held: acceptances spaced exactly WIDTH+2 cycles apart; results match a reference model over 1000 random operand pairs.

Source files
------------

// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial adder controller.
//   state_t      : FSM state encoding (ST_IDLE, ST_RUN, ST_HOLD), 2 bits
//   SA_WIDTH_DEF : default operand/result width
package serial_add_pkg;

  localparam int SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell
// Combinational one-bit full adder, the only arithmetic element of the
// serial adder.
//   x, y, z : input bits (operand A bit, operand B bit, carry in)
//   s       : sum bit      (x ^ y ^ z)
//   c       : carry out    (majority of x, y, z)
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder controller. Operands are captured on an input valid/ready
// handshake and then added one bit per cycle, LSB first, through a single
// fa_cell with a registered carry. The WIDTH-bit result and carry-out are
// offered on an output valid/ready handshake and held under backpressure.
//
// Parameters:
//   WIDTH     : operand/result width, 2..32
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : operands valid
//   in_ready  : block can accept operands (IDLE only)
//   a, b      : operands, sampled on the input handshake
//   cin       : carry-in, sampled on the input handshake
//   out_valid : result valid (HOLD)
//   out_ready : consumer accepts the result
//   sum       : a + b + cin modulo 2^WIDTH
//   cout      : carry out of bit WIDTH-1
//   busy      : high while bits are being processed (RUN)
//   ovf       : two's-complement overflow (only with SERIAL_ADD_OVF_EN)
//
// Configuration macro:
//   SERIAL_ADD_OVF_EN : adds the ovf output and its overflow logic.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t r_state;
  state_t w_stateNext;

  logic [WIDTH-1:0] r_aSr;
  logic [WIDTH-1:0] r_bSr;
  logic [WIDTH-1:0] r_sumSr;
  logic [CNT_W-1:0] r_bitCnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_inReady;
  logic             r_outValid;
  logic             r_busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             r_ovf;
`endif

  logic w_load;
  logic w_step;
  logic w_last;
  logic w_sBit;
  logic w_cBit;

  fa_cell u_faCell (
    .x (r_aSr[0]),
    .y (r_bSr[0]),
    .z (r_carry),
    .s (w_sBit),
    .c (w_cBit)
  );

  // Next-state decode and datapath strobes. IDLE waits for operands, RUN
  // processes one bit per cycle until the counter reaches the last bit, and
  // HOLD presents the result until the consumer takes it. Acceptance is only
  // possible from IDLE, so a release from HOLD always costs one IDLE cycle.
  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_bitCnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_stateNext = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // State register plus the handshake/status flags. The flags are decoded
  // from the next state so every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_inReady  <= (w_stateNext == ST_IDLE);
      r_outValid <= (w_stateNext == ST_HOLD);
      r_busy     <= (w_stateNext == ST_RUN);
    end
  end

  // Operand shift registers, carry and bit counter. The sum bit enters at
  // the MSB so that after WIDTH shifts the first (LSB) result bit has
  // arrived at position 0. The counter is held on the last bit rather than
  // incremented, so it never has to represent WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aSr    <= '0;
      r_bSr    <= '0;
      r_sumSr  <= '0;
      r_bitCnt <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
    end else if (w_load) begin
      r_aSr    <= a;
      r_bSr    <= b;
      r_carry  <= cin;
      r_bitCnt <= '0;
    end else if (w_step) begin
      r_aSr   <= {1'b0, r_aSr[WIDTH-1:1]};
      r_bSr   <= {1'b0, r_bSr[WIDTH-1:1]};
      r_sumSr <= {w_sBit, r_sumSr[WIDTH-1:1]};
      r_carry <= w_cBit;
      if (w_last) begin
        r_cout <= w_cBit;
      end else begin
        r_bitCnt <= r_bitCnt + CNT_W'(1);
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Signed overflow: on the MSB cycle r_carry is the carry into the MSB and
  // w_cBit the carry out of it; they differ exactly when the result sign is
  // wrong.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_cBit;
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign busy      = r_busy;
  assign sum       = r_sumSr;
  assign cout      = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Directed and randomized checks of serial_add_ctrl at WIDTH=8. Expected
// results come from plain integer addition of the operands; overflow from
// the operand and result sign bits. Optional checks for SERIAL_ADD_OVF_EN.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] aIn;
  logic [W-1:0] bIn;
  logic         cinIn;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] sumOut;
  logic         coutOut;
  logic         busyOut;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovfOut;
`endif

  int vectors;
  int miscompares;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (aIn),
    .b         (bIn),
    .cin       (cinIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .sum       (sumOut),
    .cout      (coutOut),
    .busy      (busyOut)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovfOut)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {cout, sum} of an addition, from ordinary arithmetic.
  function automatic logic [W:0] refAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int total;
    total = int'(x) + int'(y) + int'(c);
    return (W+1)'(total);
  endfunction

  // Expected signed overflow: both operands share a sign and the result
  // sign differs from it.
  function automatic logic refOvf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = refAdd(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Runs one complete operation: presents operands, measures latency,
  // checks the result, optionally applies backpressure for holdCycles
  // cycles (with a competing in_valid), then releases the result.
  task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB,
                               input logic opC, input int holdCycles);
    logic [W:0]   expFull;
    logic [W-1:0] heldSum;
    logic         heldCout;
    int           lat;
    expFull  = refAdd(opA, opB, opC);
    outReady = 1'b0;
    @(negedge clk);
    aIn     = opA;
    bIn     = opB;
    cinIn   = opC;
    inValid = 1'b1;
    checkOutput("ready_before_accept", 32'(inReady), 32'd1);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("busy_after_accept", 32'(busyOut), 32'd1);
    checkOutput("ready_low_in_run", 32'(inReady), 32'd0);
    lat = 0;
    while (!outValid && lat < W + 4) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(W));
    checkOutput("sum", 32'(sumOut), 32'(expFull[W-1:0]));
    checkOutput("cout", 32'(coutOut), 32'(expFull[W]));
    checkOutput("busy_low_in_hold", 32'(busyOut), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput("ovf", 32'(ovfOut), 32'(refOvf(opA, opB, opC)));
`endif
    heldSum  = sumOut;
    heldCout = coutOut;
    for (int i = 0; i < holdCycles; i++) begin
      aIn     = ~opA;
      bIn     = opB ^ 8'h5A;
      inValid = 1'b1;
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(outValid), 32'd1);
      checkOutput("bp_in_ready", 32'(inReady), 32'd0);
      checkOutput("bp_busy", 32'(busyOut), 32'd0);
      checkOutput("bp_sum_stable", 32'(sumOut), 32'(heldSum));
      checkOutput("bp_cout_stable", 32'(coutOut), 32'(heldCout));
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("valid_drop", 32'(outValid), 32'd0);
    checkOutput("ready_after_release", 32'(inReady), 32'd1);
    checkOutput("no_accept_after_release", 32'(busyOut), 32'd0);
    outReady = 1'b0;
  endtask

  initial begin
    logic [W:0] expFull;
    int         cyc;
    int         lastAcc;
    int         nAcc;
    int         nDone;
    logic       expOvf;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    inValid     = 1'b0;
    outReady    = 1'b0;
    aIn         = '0;
    bIn         = '0;
    cinIn       = 1'b0;
    expFull     = '0;
    expOvf      = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_busy", 32'(busyOut), 32'd0);
    checkOutput("rst_sum", 32'(sumOut), 32'd0);
    checkOutput("rst_cout", 32'(coutOut), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput("rst_ovf", 32'(ovfOut), 32'd0);
`endif

    $display("[TB] directed operations");
    applyStimulus(8'h0F, 8'h01, 1'b0, 0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 0);
    applyStimulus(8'h00, 8'h00, 1'b1, 0);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 0);
    applyStimulus(8'h7F, 8'h01, 1'b0, 0);
    applyStimulus(8'h80, 8'h80, 1'b0, 0);

    $display("[TB] backpressure");
    applyStimulus(8'h3C, 8'hA5, 1'b1, 5);

    $display("[TB] reset during RUN");
    @(negedge clk);
    aIn     = 8'h12;
    bIn     = 8'h34;
    cinIn   = 1'b1;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("run_busy_before_reset", 32'(busyOut), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrun_rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("midrun_rst_busy", 32'(busyOut), 32'd0);
    checkOutput("midrun_rst_sum", 32'(sumOut), 32'd0);
    checkOutput("midrun_rst_cout", 32'(coutOut), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("post_rst_out_valid", 32'(outValid), 32'd0);
    applyStimulus(8'h55, 8'hAA, 1'b0, 0);

    $display("[TB] back-to-back random operations");
    outReady = 1'b1;
    cyc      = 0;
    lastAcc  = 0;
    nAcc     = 0;
    nDone    = 0;
    while (nDone < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (outValid) begin
        checkOutput("rand_sum", 32'(sumOut), 32'(expFull[W-1:0]));
        checkOutput("rand_cout", 32'(coutOut), 32'(expFull[W]));
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("rand_ovf", 32'(ovfOut), 32'(expOvf));
`endif
        nDone++;
      end
      if (inReady) begin
        if (nAcc > 0) begin
          checkOutput("init_interval", 32'(cyc - lastAcc), 32'(W + 2));
        end
        if (nAcc < 1000) begin
          aIn     = W'($urandom);
          bIn     = W'($urandom);
          cinIn   = 1'($urandom);
          expFull = refAdd(aIn, bIn, cinIn);
          expOvf  = refOvf(aIn, bIn, cinIn);
          inValid = 1'b1;
          lastAcc = cyc;
          nAcc++;
        end else begin
          inValid = 1'b0;
        end
      end
    end
    inValid  = 1'b0;
    outReady = 1'b0;
    checkOutput("rand_all_done", 32'(nDone), 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
